// File: rtl/matrix_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : matrix_scan_controller
// Brief    : Column-multiplexed 5x7 dot-matrix scan controller; optional
//            slow vertical scroll of the shown character (MATRIX_SCROLL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module matrix_scan_controller #(
    parameter int DWELL           = 1000,
    parameter int FRAMES_PER_STEP = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [34:0] char_data,
    output logic        char_ready,
    output logic        ch1,
    output logic        ch0,
    output logic [6:0]  bits,
    output logic        d,
    output logic [4:0]  col_en,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_DWELL   = 2'd2,
        ST_ADVANCE = 2'd3
    } state_t;

    localparam logic [15:0] c_dwell_last = 16'(DWELL - 1);
    localparam logic [2:0]  c_last_col   = 3'd4;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_col;
    logic [15:0] r_cnt;
    logic [34:0] r_buf;
    logic [6:0]  w_col_bits;
    logic        w_accept;
    logic        w_frame_end;

    assign w_accept    = char_valid & char_ready;
    assign w_frame_end = (r_state == ST_ADVANCE) && (r_col == c_last_col);
    assign d           = 1'b0;

    always_comb begin
        case (r_col)
            3'd0:    w_col_bits = r_buf[6:0];
            3'd1:    w_col_bits = r_buf[13:7];
            3'd2:    w_col_bits = r_buf[20:14];
            3'd3:    w_col_bits = r_buf[27:21];
            3'd4:    w_col_bits = r_buf[34:28];
            default: w_col_bits = 7'd0;
        endcase
    end

    // Modes 10 (shift) and 11 (rotate) are never used: ch1 stays low.
    always_comb begin
        w_state_nxt = r_state;
        ch1         = 1'b0;
        ch0         = 1'b0;
        bits        = 7'd0;
        col_en      = 5'd0;
        char_ready  = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                char_ready = 1'b1;
                if (char_valid) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                ch0         = 1'b1;
                bits        = w_col_bits;
                w_state_nxt = ST_DWELL;
            end
            ST_DWELL: begin
                col_en = 5'd1 << r_col;
                if (r_cnt == c_dwell_last) w_state_nxt = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                char_ready  = w_frame_end;
                frame_done  = w_frame_end;
                w_state_nxt = ST_LOAD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef MATRIX_SCROLL_EN
    localparam logic [7:0] c_fps_last = 8'(FRAMES_PER_STEP - 1);

    logic [7:0]  r_frame_cnt;
    logic [34:0] w_rot;
    logic        w_step;

    for (genvar g = 0; g < 5; g++) begin : g_rot
        assign w_rot[7*g +: 7] = {r_buf[7*g +: 6], r_buf[7*g + 6]};
    end

    assign w_step = w_frame_end && (r_frame_cnt == c_fps_last);

    always_ff @(posedge clk) begin
        if (rst)                  r_frame_cnt <= 8'd0;
        else if (w_accept)        r_frame_cnt <= 8'd0;
        else if (w_step)          r_frame_cnt <= 8'd0;
        else if (w_frame_end)     r_frame_cnt <= r_frame_cnt + 8'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_col   <= 3'd0;
            r_cnt   <= 16'd0;
            r_buf   <= 35'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_col <= 3'd0;
                    if (w_accept) r_buf <= char_data;
                end
                ST_LOAD:  r_cnt <= 16'd0;
                ST_DWELL: r_cnt <= r_cnt + 16'd1;
                ST_ADVANCE: begin
                    r_col <= (r_col == c_last_col) ? 3'd0 : r_col + 3'd1;
                    // A new character at the frame boundary beats a scroll step.
                    if (w_accept) r_buf <= char_data;
`ifdef MATRIX_SCROLL_EN
                    else if (w_step) r_buf <= w_rot;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_scan_controller
// Brief    : Directed self-checking bench for matrix_scan_controller (DWELL=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_controller;

    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        char_valid = 1'b0;
    logic [34:0] char_data = 35'd0;
    logic        char_ready, ch1, ch0, d, frame_done;
    logic [6:0]  bits;
    logic [4:0]  col_en;

    int checks   = 0;
    int failures = 0;
    int idx      = 0;

    // Column c holds 1<<c; used by several tests.
    localparam logic [34:0] c_walk = {7'h10, 7'h08, 7'h04, 7'h02, 7'h01};
    localparam logic [34:0] c_new  = {7'h11, 7'h22, 7'h33, 7'h44, 7'h55};

    matrix_scan_controller #(.DWELL(DW), .FRAMES_PER_STEP(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .ch1        (ch1),
        .ch0        (ch0),
        .bits       (bits),
        .d          (d),
        .col_en     (col_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        idx++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Handshake from IDLE; returns while observing the first LOAD (idx 0).
    task automatic start_char(input logic [34:0] data);
        char_valid = 1'b1;
        char_data  = data;
        @(negedge clk);
        char_valid = 1'b0;
        idx = 0;
    endtask

    task automatic test_reset();
        char_valid = 1'b1;
        char_data  = c_walk;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({char_ready, col_en, ch1, ch0, bits, frame_done, d} !== {1'b1, 5'd0, 2'b00, 7'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_outputs rdy=%b col_en=%b ch=%b%b bits=%h fd=%b d=%b exp rdy=1 col_en=0 ch=00 bits=0 fd=0 d=0",
                     char_ready, col_en, ch1, ch0, bits, frame_done, d);
        end
        rst = 1'b0;
        char_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({char_ready, ch0, col_en} !== {1'b1, 1'b0, 5'd0}) begin
            failures++;
            $display("FAIL reset_discard rdy=%b ch0=%b col_en=%b exp rdy=1 ch0=0 col_en=0", char_ready, ch0, col_en);
        end
    endtask

    task automatic test_scan();
        do_reset();
        start_char(c_walk);
        checks++;
        if ({ch1, ch0, bits, col_en, char_ready} !== {2'b01, 7'h01, 5'd0, 1'b0}) begin
            failures++;
            $display("FAIL scan_load0 ch=%b%b bits=%h col_en=%b rdy=%b exp ch=01 bits=01 col_en=0 rdy=0",
                     ch1, ch0, bits, col_en, char_ready);
        end
        for (int k = 0; k < DW; k++) begin
            step();
            checks++;
            if ({col_en, ch1, ch0} !== {5'b00001, 2'b00}) begin
                failures++;
                $display("FAIL scan_dwell0 k=%0d col_en=%b ch=%b%b exp col_en=00001 ch=00", k, col_en, ch1, ch0);
            end
        end
        step();
        checks++;
        if ({col_en, ch1, ch0, frame_done} !== {5'd0, 2'b00, 1'b0}) begin
            failures++;
            $display("FAIL scan_advance col_en=%b ch=%b%b fd=%b exp col_en=0 ch=00 fd=0", col_en, ch1, ch0, frame_done);
        end
        step();
        checks++;
        if ({ch1, ch0, bits, col_en} !== {2'b01, 7'h02, 5'd0}) begin
            failures++;
            $display("FAIL scan_load1 ch=%b%b bits=%h col_en=%b exp ch=01 bits=02 col_en=0", ch1, ch0, bits, col_en);
        end
        step();
        checks++;
        if (col_en !== 5'b00010) begin
            failures++;
            $display("FAIL scan_dwell1 col_en=%b exp 00010", col_en);
        end
    endtask

    // Frame = 30 cycles; LOAD of column c at 6c, frame_done on the 30th cycle.
    task automatic test_frame_timing();
        int ph, c;
        logic [4:0] exp_en;
        do_reset();
        start_char(c_walk);
        for (int i = 0; i < 90; i++) begin
            if (i > 0) step();
            ph = idx % 6;
            c  = (idx / 6) % 5;
            exp_en = (ph >= 1 && ph <= DW) ? 5'(1 << c) : 5'd0;
            checks++;
            if (frame_done !== (idx % 30 == 29)) begin
                failures++;
                $display("FAIL frame_done idx=%0d got=%b exp=%b", idx, frame_done, (idx % 30 == 29));
            end
            checks++;
            if (col_en !== exp_en) begin
                failures++;
                $display("FAIL frame_col_en idx=%0d got=%b exp=%b", idx, col_en, exp_en);
            end
            checks++;
            if (char_ready !== (idx % 30 == 29)) begin
                failures++;
                $display("FAIL frame_ready idx=%0d got=%b exp=%b", idx, char_ready, (idx % 30 == 29));
            end
            if (ph == 0) begin
                checks++;
                if ({ch0, bits} !== {1'b1, 7'(1 << c)}) begin
                    failures++;
                    $display("FAIL frame_bits idx=%0d ch0=%b bits=%h exp ch0=1 bits=%h", idx, ch0, bits, 7'(1 << c));
                end
            end
        end
    endtask

    task automatic test_midframe_handshake();
        do_reset();
        start_char(c_walk);
        while (idx < 13) step();
        char_valid = 1'b1;
        char_data  = c_new;
        while (idx < 29) begin
            step();
            if (idx < 29) begin
                checks++;
                if (char_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL mid_ready_low idx=%0d got=%b exp=0", idx, char_ready);
                end
            end
            if (idx == 18) begin
                checks++;
                if (bits !== 7'h08) begin
                    failures++;
                    $display("FAIL mid_old_col3 bits=%h exp=08", bits);
                end
            end
        end
        checks++;
        if (char_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_ready_boundary got=%b exp=1", char_ready);
        end
        step();
        char_valid = 1'b0;
        checks++;
        if ({ch0, bits} !== {1'b1, 7'h55}) begin
            failures++;
            $display("FAIL mid_new_col0 ch0=%b bits=%h exp ch0=1 bits=55", ch0, bits);
        end
        while (idx < 36) step();
        checks++;
        if (bits !== 7'h44) begin
            failures++;
            $display("FAIL mid_new_col1 bits=%h exp=44", bits);
        end
    endtask

    task automatic test_reset_during_scan();
        do_reset();
        start_char(c_walk);
        while (idx < 14) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({col_en, char_ready, ch1, ch0} !== {5'd0, 1'b1, 2'b00}) begin
            failures++;
            $display("FAIL rst_scan col_en=%b rdy=%b ch=%b%b exp col_en=0 rdy=1 ch=00", col_en, char_ready, ch1, ch0);
        end
        step();
        checks++;
        if ({col_en, char_ready, ch0} !== {5'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL rst_scan_idle col_en=%b rdy=%b ch0=%b exp col_en=0 rdy=1 ch0=0", col_en, char_ready, ch0);
        end
    endtask

    // Column 0 LOAD of frame k is at idx 30k.
    task automatic test_scroll();
        logic [6:0] exp_b;
        do_reset();
        start_char({28'd0, 7'b0000001});
        exp_b = 7'b0000001;
        for (int k = 0; k < 8; k++) begin
            while (idx < 30 * k) step();
            checks++;
            if ({ch0, bits} !== {1'b1, exp_b}) begin
                failures++;
                $display("FAIL scroll_frame%0d ch0=%b bits=%b exp ch0=1 bits=%b", k + 1, ch0, bits, exp_b);
            end
`ifdef MATRIX_SCROLL_EN
            exp_b = {exp_b[5:0], exp_b[6]};
`endif
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_frame_timing();
        test_midframe_handshake();
        test_reset_during_scan();
        test_scroll();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_scan_controller.md
MATRIX_SCAN_CONTROLLER -- requirements
Module: matrix_scan_controller

Interface
REQ-001 The block SHALL have parameter DWELL, default 1000, giving the number of clock cycles each column is lit (legal range 1..65535).
REQ-002 The block SHALL have parameter FRAMES_PER_STEP, default 64, giving the number of frames per scroll step (legal range 1..255).
REQ-003 The block SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port char_valid  input  1  requester offers a new 5x7 character.
REQ-006 The block SHALL have port char_data  input  35  character pattern; bits [7c+6:7c] are column c (c=0..4), bit 0 is the top row.
REQ-007 The block SHALL have port char_ready  output  1  controller accepts char_data this cycle.
REQ-008 The block SHALL have ports ch1, ch0  output  1 each  column-register mode: 00 hold, 01 parallel load, 10 shift d in, 11 rotate.
REQ-009 The block SHALL have port bits  output  7  parallel-load value for the column register.
REQ-010 The block SHALL have port d  output  1  serial input to the column register; driven 0 at all times.
REQ-011 The block SHALL have port col_en  output  5  one-hot column enable, with 0 meaning blanked.
REQ-012 The block SHALL have port frame_done  output  1  one-cycle pulse at the end of each 5-column frame.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, DWELL and ADVANCE, a 3-bit column index (0..4, never above 4) and a 16-bit dwell counter.
REQ-014 In IDLE the block SHALL drive char_ready=1, ch1ch0=00 and col_en=0; on char_valid&char_ready it SHALL capture char_data into a 35-bit buffer, set column=0 and go to LOAD.
REQ-015 LOAD SHALL last exactly 1 cycle with ch1ch0=01, bits=buffer column[col] and col_en=0, and then go to DWELL with the counter cleared.
REQ-016 DWELL SHALL drive ch1ch0=00 and col_en=1<<col, and SHALL increment the counter each cycle until counter==DWELL-1, then go to ADVANCE.
REQ-017 ADVANCE SHALL last exactly 1 cycle with col_en=0 and ch1ch0=00.
REQ-018 In ADVANCE, if col<4 the block SHALL set col=col+1; if col==4 it SHALL set col=0 and pulse frame_done for that cycle. ADVANCE SHALL always go to LOAD.
REQ-019 One column SHALL take DWELL+2 cycles and one frame SHALL take 5*(DWELL+2) cycles.
REQ-020 char_ready SHALL be 1 only in IDLE and in ADVANCE with col==4 (the frame boundary); a handshake there SHALL replace the buffer, and the new pattern SHALL take effect at the next LOAD (column 0).
REQ-021 char_valid outside a char_ready cycle SHALL be ignored; the requester holds char_valid and char_data until the handshake.
REQ-022 After the first accepted character the block SHALL refresh continuously and SHALL NOT return to IDLE except through reset.
REQ-023 Mode 10 SHALL never be driven, and mode 11 SHALL never be driven.

Reset
REQ-024 When rst=1 at a clk edge, the block SHALL enter IDLE with col=0, counter=0, buffer=0, frame counter=0, ch1ch0=00, bits=0, d=0, col_en=0, frame_done=0 and char_ready=1, regardless of state.
REQ-025 rst SHALL take priority over a simultaneous char_valid handshake; a character offered in a reset cycle SHALL be discarded.
REQ-026 Reset asserted mid-frame SHALL blank col_en on the following cycle and SHALL discard the buffer.

Configuration
REQ-027 With macro MATRIX_SCROLL_EN defined, an 8-bit frame counter SHALL increment at each frame_done.
REQ-028 With MATRIX_SCROLL_EN defined, when the frame counter reaches FRAMES_PER_STEP-1 the counter SHALL clear and every buffer column SHALL rotate as {b[5:0],b[6]} in the same ADVANCE cycle.
REQ-029 With MATRIX_SCROLL_EN defined, a simultaneous character handshake SHALL win over rotation and SHALL clear the frame counter.
REQ-030 Without MATRIX_SCROLL_EN the buffer SHALL be static between handshakes and no frame counter logic SHALL exist.

Verification
REQ-031 Reset test: with rst=1 for 2 cycles, the bench SHALL check char_ready=1, col_en=0, ch1ch0=00, bits=0 and frame_done=0.
REQ-032 Scan test: with DWELL=4 and char_data column0=7'h01 ... column4=7'h10, the bench SHALL check LOAD with bits=7'h01, then col_en=5'b00001 for 4 cycles, then blank, then bits=7'h02 and col_en=5'b00010.
REQ-033 Frame timing test: with DWELL=4, the bench SHALL check that frame_done pulses exactly 30 cycles after the first LOAD and every 30 cycles after that.
REQ-034 Mid-frame handshake test: with char_valid raised during DWELL of column 2, the bench SHALL check char_ready=0 until ADVANCE of column 4, and that the new column 0 appears at the next LOAD.
REQ-035 Reset during scan test: with rst pulsed during DWELL of column 2, the bench SHALL check IDLE next cycle with col_en=0 and char_ready=1.
REQ-036 Scroll test: with MATRIX_SCROLL_EN defined, FRAMES_PER_STEP=1 and column0=7'b0000001, the bench SHALL check that the second frame loads 7'b0000010 and the eighth frame loads 7'b0000001.
